// File: rtl/key_event_pkg.sv
// Shared types for the key event encoder: event codes, per-key FSM states
// and a small elaboration-time helper.
package key_event_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2,
    EV_REPEAT  = 2'd3
  } ev_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } key_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO holding queued key events; pointers carry an extra
// wrap bit so full and empty are told apart without a separate counter.
module key_event_fifo #(
  parameter int FD = 4,
  parameter int W  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(FD);

  logic [W-1:0] mem [FD];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; the read side is masked while empty, so stale
  // contents are never visible and the array stays a plain RAM.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  // NOTE: non-blocking assignments for every register, so all state in the
  // design updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/key_event.sv
// Key event encoder: per-key press/release/long/repeat detection, one-entry
// pending slots, fixed-priority arbiter and event FIFO. KEY_EVENT_REPEAT_EN enables REPEAT.
module key_event
  import key_event_pkg::*;
#(
  parameter int  DW = 2,
  parameter int  CL = 5_000_000,
  parameter int  CR = 500_000,
  parameter int  FD = 4,
  localparam int KW = (DW > 1) ? $clog2(DW) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d_i,
  output logic          e_vld,
  input  logic          e_rdy,
  output logic [KW-1:0] e_key,
  output logic [1:0]    e_code,
  output logic          ovf
);

  localparam int CW = $clog2(max_int(CL, CR));
  localparam int EW = KW + 2;

  logic [DW-1:0] slot_vld;
  logic [DW-1:0] grant;
  logic [DW-1:0] drop;
  logic [1:0]    slot_code [DW];
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] push_data;
  logic [EW-1:0] head;

  for (genvar g = 0; g < DW; g++) begin : g_key
    // Mask of keys that outrank this one in the arbiter.
    localparam logic [DW-1:0] HIGHER = DW'((1 << g) - 1);

    key_state_t    state;
    logic [CW-1:0] cnt;
    logic          d_r;
    logic          rise;
    logic          fall;
    logic          raise;
    ev_code_t      raise_code;
    logic          vld_q;
    ev_code_t      code_q;

    assign rise = d_i[g] & ~d_r;
    assign fall = ~d_i[g] & d_r;

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value held and no latch is inferred.
    always_comb begin
      raise      = 1'b0;
      raise_code = EV_PRESS;
      case (state)
        ST_IDLE: raise = rise;
        ST_HELD: begin
          if (fall) begin
            raise      = 1'b1;
            raise_code = EV_RELEASE;
          end else if (cnt == CW'(CL - 1)) begin
            raise      = 1'b1;
            raise_code = EV_LONG;
          end
        end
        ST_LONG: begin
          if (fall) begin
            raise      = 1'b1;
            raise_code = EV_RELEASE;
          end
`ifdef KEY_EVENT_REPEAT_EN
          else if (cnt == CW'(CR - 1)) begin
            raise      = 1'b1;
            raise_code = EV_REPEAT;
          end
`endif
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= ST_IDLE;
        cnt   <= '0;
        d_r   <= 1'b0;
      end else begin
        d_r <= d_i[g];
        case (state)
          ST_IDLE: begin
            if (rise) begin
              state <= ST_HELD;
              cnt   <= '0;
            end
          end
          ST_HELD: begin
            if (fall) begin
              state <= ST_IDLE;
            end else if (cnt == CW'(CL - 1)) begin
              state <= ST_LONG;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_LONG: begin
            if (fall) begin
              state <= ST_IDLE;
            end else begin
`ifdef KEY_EVENT_REPEAT_EN
              cnt <= (cnt == CW'(CR - 1)) ? '0 : cnt + CW'(1);
`else
              cnt <= '0;
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    // A slot granted this cycle counts as free, so it can be reloaded at once.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        code_q <= EV_PRESS;
      end else if (raise && (!vld_q || grant[g])) begin
        vld_q  <= 1'b1;
        code_q <= raise_code;
      end else if (grant[g]) begin
        vld_q <= 1'b0;
      end
    end

    assign slot_vld[g]  = vld_q;
    assign slot_code[g] = code_q;
    assign grant[g]     = vld_q && !fifo_full && ((slot_vld & HIGHER) == '0);
    assign drop[g]      = raise && vld_q && !grant[g];
  end

  always_comb begin
    push_data = '0;
    for (int i = 0; i < DW; i++) begin
      if (grant[i]) push_data = {KW'(i), slot_code[i]};
    end
  end

  assign push = |grant;
  assign pop  = e_vld & e_rdy;

  key_event_fifo #(
    .FD(FD),
    .W (EW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (push_data),
    .full (fifo_full),
    .pop  (pop),
    .empty(fifo_empty),
    .dout (head)
  );

  always_ff @(posedge clk) begin
    if (rst)        ovf <= 1'b0;
    else if (|drop) ovf <= 1'b1;
  end

  assign e_vld  = !fifo_empty;
  assign e_key  = e_vld ? head[EW-1:2] : '0;
  assign e_code = e_vld ? head[1:0]    : 2'b00;

endmodule

// File: doc/key_event.md
# key_event

Key event encoder downstream of the `debouncer` array. It takes `DW` debounced, clock-synchronous key levels and detects press, release, long-press and auto-repeat per key. Events are queued in a small FIFO and presented as a valid/ready stream of (key index, event code) to the host interface, such as a CPU register or IRQ logic.

## Interface
- `DW`, 2: number of keys; must match the debouncer array width.
- `CL`, 5_000_000: long-press threshold in clock cycles (1 s at 200 ns clock); ≥2.
- `CR`, 500_000: auto-repeat period in clock cycles (100 ms); ≥2.
- `FD`, 4: event FIFO depth; power of two, ≥2.

- `clk`  in  1  clock; every register is updated on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `d_i`  in  DW  debounced key levels (1 = pressed), from debouncer `d_o`.
- `e_vld`  out  1  event available at FIFO head.
- `e_rdy`  in  1  consumer accepts the head event.
- `e_key`  out  KW  key index of the head event; KW = max(1, $clog2(DW)).
- `e_code`  out  2  event code: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
- `ovf`  out  1  sticky: set when an event was dropped; cleared only by `rst`.

## Operation
- **Edge detection:** per key, `d_r` is a one-cycle delayed copy of `d_i`.
  - A rise is `d_i & ~d_r`.
  - A fall is `~d_i & d_r`.
- **Per-key FSM states:** IDLE, HELD, LONG. Each key has a counter `cnt`, width $clog2(max(CL,CR)).
  - IDLE, on rise: raise PRESS, set `cnt` = 0, go to HELD.
  - HELD: `cnt` += 1 each cycle. When `cnt` == CL-1, raise LONG, set `cnt` = 0, go to LONG.
  - LONG: with repeat enabled, `cnt` += 1. When `cnt` == CR-1, raise REPEAT and set `cnt` = 0. Stay in LONG.
  - HELD or LONG, on fall: raise RELEASE, go to IDLE. A fall takes precedence over a counter match in the same cycle.
  - A rise while in HELD or LONG (not possible behind the debouncer) is ignored.
- **Pending slot:** each key has a one-entry pending slot (valid bit + code).
  - A raised event loads the slot.
  - If the slot is still valid when a new event is raised, the new event is dropped and `ovf` is set. The slot keeps its old event.
- **Arbiter:** fixed priority, lowest key index first. It moves at most one pending slot into the FIFO per cycle, only when FIFO count < FD.
  - The push decision ignores a same-cycle pop. A full FIFO never accepts a push, even while popping.
  - A slot drained in cycle k may be reloaded in cycle k.
- **FIFO:**
  - `e_vld` = !empty.
  - A pop occurs on `e_vld & e_rdy`.
  - `e_key`/`e_code` show the head entry and are stable while `e_vld & ~e_rdy`.
  - Pointers are FD-wrapping, with an extra MSB for the full/empty distinction.

## Timing
- **Reset values:**
  - `e_vld` = 0, `ovf` = 0.
  - `e_key` = 0, `e_code` = 0 (FIFO storage is not reset; outputs are masked to 0 when empty).
  - All FSMs in IDLE, `cnt` = 0, `d_r` = 0, pending slots invalid, FIFO empty.
- **Key held through reset:** because `d_r` resets to 0, a PRESS is raised on the first edge after `rst` falls.
- **Reset mid-operation:** the queue and pending events are discarded, with no partial output.
- **Latency** (no contention, FIFO empty):
  - `d_i` rise sampled at edge k: slot loaded at k, FIFO pushed at k+1, `e_vld` high after k+1.
  - LONG is raised at edge k+CL, where k is the PRESS edge.
  - REPEAT is raised every CR edges after LONG.
- **Throughput:** 1 event/cycle in and out.
- **Contention:** when all DW keys raise events in the same cycle, drain takes DW cycles.

## Configuration
- **`KEY_EVENT_REPEAT_EN` defined:** LONG state generates REPEAT every CR cycles, as described above.
- **Undefined:**
  - LONG holds `cnt` at 0 and raises nothing until the fall.
  - Code 3 is never produced.
  - `CR` is accepted but unused.

## Structure
- **Package `key_event_pkg`:**
  - Event code constants PRESS/RELEASE/LONG/REPEAT (2-bit).
  - FSM state encoding IDLE/HELD/LONG.
- **Sub-module `key_event_fifo`:**
  - Parameters: FD depth, data width KW+2.
  - Ports: `clk`, `rst`, push/data-in, full, pop, empty, data-out.
- Per-key FSM, pending slots and arbiter live in the top module, inside a generate loop over DW.

## Test plan
All scenarios use CL=8, CR=4, FD=2, DW=2, `e_rdy`=1 unless stated.
- **Single press/release:** key0 rises, held 3 cycles, falls. Expect (0,PRESS) with `e_vld` 2 cycles after the rise, then (0,RELEASE). No LONG.
- **Long and repeat:** key1 held 20 cycles.
  - Expect (1,PRESS), then (1,LONG) 8 cycles after PRESS, then (1,REPEAT) at +4 and +8.
  - Then (1,RELEASE).
  - With the macro undefined: no REPEAT.
- **Simultaneous press:** both keys rise in the same cycle. Expect (0,PRESS) then (1,PRESS) on consecutive cycles, and `ovf` = 0.
- **Backpressure:** `e_rdy`=0 while keys 0 and 1 press then release.
  - FIFO fills with 2 events; the pending slots hold the releases.
  - A further event on key0 sets `ovf` = 1.
  - When `e_rdy`=1, the order is P0, P1, R0, R1.
- **Reset with key held:** key0 held, `rst` pulsed for 1 cycle mid-LONG. The queue is cleared and `ovf` = 0; (0,PRESS) appears 2 cycles after reset deasserts.
